// File: rtl/sram_readback_checker.sv
// Purpose: checks an SRAM read-back stream against the pattern data[i] = SEED - i, address[i] = i.
// Latency: each beat is scored on its sampling edge; busy/done/pass/timeout/err_count update one cycle later.
// Backpressure: none; the checker always accepts rd_valid in CHECK and aborts to TOUT after TIMEOUT idle cycles.
module sram_readback_checker #(
   parameter int NUM_WORDS = 128,
   parameter int SEED      = 127,
   parameter int TIMEOUT   = 1023
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        start,
   input  logic        rd_valid,
   input  logic [10:0] rd_addr,
   input  logic [15:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [7:0]  err_count,
   output logic [10:0] first_err_addr,
   output logic [15:0] first_err_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2,
      TOUT  = 2'd3
   } state_t;

   localparam logic [10:0] LAST_IDX  = 11'(NUM_WORDS - 1);
   localparam logic [15:0] SEED_W    = 16'(SEED);
   localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic [10:0] idx;
   logic [15:0] idle_cnt;

   logic [15:0] exp_data;
   logic        beat_err;
   logic [7:0]  err_next;

   // Score the current beat against the expected pattern and form the saturating error count.
   always_comb begin
      exp_data = SEED_W - {5'd0, idx};
      beat_err = (rd_addr != idx) || (rd_data != exp_data);
      err_next = err_count;
      if (beat_err && (err_count != 8'hFF)) begin
         err_next = err_count + 8'd1;
      end
   end

   // Run FSM; every output is registered alongside the state that implies it.
   always_ff @(posedge clock) begin
      if (rst) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         err_count      <= 8'd0;
         first_err_addr <= 11'd0;
         first_err_data <= 16'd0;
         idx            <= 11'd0;
         idle_cnt       <= 16'd0;
      end else begin
         case (state)
            IDLE, DONE, TOUT: begin
               if (start) begin
                  state          <= CHECK;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  timeout        <= 1'b0;
                  err_count      <= 8'd0;
                  first_err_addr <= 11'd0;
                  first_err_data <= 16'd0;
                  idx            <= 11'd0;
                  idle_cnt       <= 16'd0;
               end
            end
            CHECK: begin
               if (rd_valid) begin
                  // A beat always wins over an expiring idle counter.
                  idle_cnt  <= 16'd0;
                  err_count <= err_next;
                  if (beat_err && (err_count == 8'd0)) begin
                     first_err_addr <= rd_addr;
                     first_err_data <= rd_data;
                  end
                  if (idx == LAST_IDX) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == 8'd0);
                  end else begin
                     idx <= idx + 11'd1;
                  end
               end else begin
                  idle_cnt <= idle_cnt + 16'd1;
                  if (idle_cnt == IDLE_LAST) begin
                     state   <= TOUT;
                     busy    <= 1'b0;
                     timeout <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_readback_checker.sv
// Bench for sram_readback_checker: directed scenarios plus randomized runs scored every cycle
// against a run-level reference model (beats seen, errors seen, idle gap length).
// NUM_WORDS is raised to 300 so error saturation is reachable; TIMEOUT is shortened to keep runs brief.
module tb_sram_readback_checker;

   localparam int NW   = 300;
   localparam int SEED = 127;
   localparam int TMO  = 50;

   logic        clock = 1'b0;
   logic        rst;
   logic        start;
   logic        rd_valid;
   logic [10:0] rd_addr;
   logic [15:0] rd_data;
   logic        busy;
   logic        done;
   logic        pass;
   logic        timeout;
   logic [7:0]  err_count;
   logic [10:0] first_err_addr;
   logic [15:0] first_err_data;

   sram_readback_checker #(
      .NUM_WORDS (NW),
      .SEED      (SEED),
      .TIMEOUT   (TMO)
   ) dut (
      .clock          (clock),
      .rst            (rst),
      .start          (start),
      .rd_valid       (rd_valid),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .timeout        (timeout),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .first_err_data (first_err_data)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model: a run is either active or finished (with done or timed-out flag).
   bit          m_active;
   bit          m_done;
   bit          m_pass;
   bit          m_tout;
   int          m_beats;
   int          m_errs;
   int          m_gap;
   logic [10:0] m_fa;
   logic [15:0] m_fd;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] good_data(input int i);
      return 16'(SEED - i);
   endfunction

   task automatic model_clear();
      m_active = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_tout = 1'b0;
      m_beats = 0; m_errs = 0; m_gap = 0; m_fa = '0; m_fd = '0;
   endtask

   // Advance the model by one clock edge using the inputs presented at that edge.
   task automatic model_edge();
      bit bad;
      if (rst) begin
         model_clear();
      end else if (!m_active) begin
         if (start) begin
            model_clear();
            m_active = 1'b1;
         end
      end else if (rd_valid) begin
         bad = (int'(rd_addr) != m_beats) || (rd_data != good_data(m_beats));
         if (bad) begin
            if (m_errs == 0) begin
               m_fa = rd_addr;
               m_fd = rd_data;
            end
            if (m_errs < 255) m_errs++;
         end
         m_beats++;
         m_gap = 0;
         if (m_beats == NW) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_pass   = (m_errs == 0);
         end
      end else begin
         m_gap++;
         if (m_gap == TMO) begin
            m_active = 1'b0;
            m_tout   = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check_eq("busy", busy, m_active);
      check_eq("done", done, m_done);
      check_eq("pass", pass, m_pass);
      check_eq("timeout", timeout, m_tout);
      check_eq("err_count", err_count, m_errs);
      check_eq("first_err_addr", first_err_addr, m_fa);
      check_eq("first_err_data", first_err_data, m_fd);
   endtask

   task automatic cyc(input logic r, input logic s, input logic v,
                      input logic [10:0] a, input logic [15:0] d);
      rst = r; start = s; rd_valid = v; rd_addr = a; rd_data = d;
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle_n(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 11'd0, 16'd0);
   endtask

   task automatic good_beat(input int i);
      cyc(1'b0, 1'b0, 1'b1, 11'(i), good_data(i));
   endtask

   initial begin
      model_clear();
      rst = 1'b1; start = 1'b0; rd_valid = 1'b0; rd_addr = '0; rd_data = '0;
      #1;
      cyc(1'b1, 1'b0, 1'b0, 11'd0, 16'd0);
      cyc(1'b1, 1'b1, 1'b0, 11'd0, 16'd0);
      check_eq("reset_busy", busy, 1'b0);
      check_eq("reset_err", err_count, 8'd0);

      // A beat while IDLE must be ignored.
      cyc(1'b0, 1'b0, 1'b1, 11'd0, 16'h1234);
      check_eq("idle_beat_err", err_count, 8'd0);

      // Clean back-to-back run.
      cyc(1'b0, 1'b1, 1'b0, 11'd0, 16'd0);
      check_eq("clean_busy", busy, 1'b1);
      for (int i = 0; i < NW; i++) good_beat(i);
      check_eq("clean_done", done, 1'b1);
      check_eq("clean_pass", pass, 1'b1);
      check_eq("clean_err", err_count, 8'd0);
      // A beat in DONE must not disturb the result.
      cyc(1'b0, 1'b0, 1'b1, 11'd7, 16'h0000);
      check_eq("done_hold_pass", pass, 1'b1);

      // Restart from DONE; corrupt beat 5 data.
      cyc(1'b0, 1'b1, 1'b0, 11'd0, 16'd0);
      for (int i = 0; i < NW; i++)
         cyc(1'b0, 1'b0, 1'b1, 11'(i), (i == 5) ? 16'h0000 : good_data(i));
      check_eq("corrupt_done", done, 1'b1);
      check_eq("corrupt_pass", pass, 1'b0);
      check_eq("corrupt_err", err_count, 8'd1);
      check_eq("corrupt_faddr", first_err_addr, 11'd5);
      check_eq("corrupt_fdata", first_err_data, 16'h0000);

      // Gapped beats, all data 0xFFFF: saturation without timeout.
      cyc(1'b0, 1'b1, 1'b0, 11'd0, 16'd0);
      for (int i = 0; i < NW; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 11'(i), 16'hFFFF);
         if (i != NW - 1) idle_n(3);
      end
      check_eq("sat_err", err_count, 8'd255);
      check_eq("sat_faddr", first_err_addr, 11'd0);
      check_eq("sat_tout", timeout, 1'b0);
      check_eq("sat_done", done, 1'b1);

      // Timeout: a gap of TMO-1 survives, then a gap of TMO aborts.
      cyc(1'b0, 1'b1, 1'b0, 11'd0, 16'd0);
      for (int i = 0; i < 10; i++) good_beat(i);
      idle_n(TMO - 1);
      check_eq("gap_edge_busy", busy, 1'b1);
      good_beat(10);
      idle_n(TMO);
      check_eq("tout_flag", timeout, 1'b1);
      check_eq("tout_busy", busy, 1'b0);
      check_eq("tout_err", err_count, 8'd0);
      cyc(1'b0, 1'b0, 1'b1, 11'd11, 16'h0000);
      check_eq("tout_hold_err", err_count, 8'd0);
      cyc(1'b0, 1'b1, 1'b0, 11'd0, 16'd0);
      check_eq("restart_tout", timeout, 1'b0);
      check_eq("restart_busy", busy, 1'b1);

      // Address skip 0,1,3 (data correct for idx); start mid-run is ignored.
      good_beat(0);
      cyc(1'b0, 1'b1, 1'b1, 11'd1, good_data(1));
      cyc(1'b0, 1'b0, 1'b1, 11'd3, good_data(2));
      check_eq("skip_err", err_count, 8'd1);
      check_eq("skip_faddr", first_err_addr, 11'd3);
      check_eq("skip_busy", busy, 1'b1);

      // Reset mid-run at beat 60 after an error at beat 10, with start alongside rst.
      cyc(1'b1, 1'b0, 1'b0, 11'd0, 16'd0);
      cyc(1'b0, 1'b1, 1'b0, 11'd0, 16'd0);
      for (int i = 0; i < 60; i++)
         cyc(1'b0, 1'b0, 1'b1, 11'(i), (i == 10) ? 16'hBEEF : good_data(i));
      check_eq("pre_rst_err", err_count, 8'd1);
      cyc(1'b1, 1'b1, 1'b1, 11'd60, good_data(60));
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_err", err_count, 8'd0);
      check_eq("rst_faddr", first_err_addr, 11'd0);
      check_eq("rst_fdata", first_err_data, 16'd0);
      idle_n(1);
      check_eq("rst_idle_busy", busy, 1'b0);

      // Randomized runs: random gaps, occasional long gaps, corruption, stray starts and resets.
      for (int run = 0; run < 10; run++) begin
         cyc(1'b0, 1'b1, 1'b0, 11'd0, 16'd0);
         for (int c = 0; c < 4000 && m_active; c++) begin
            if ($urandom_range(0, 299) == 0) begin
               idle_n($urandom_range(TMO - 5, TMO + 5));
            end else if ($urandom_range(0, 2999) == 0) begin
               cyc(1'b1, $urandom_range(0, 1) == 1, 1'b1, 11'(m_beats), good_data(m_beats));
            end else begin
               logic        v;
               logic [10:0] a;
               logic [15:0] d;
               v = ($urandom_range(0, 3) != 0);
               a = 11'(m_beats);
               d = good_data(m_beats);
               if ($urandom_range(0, 49) == 0) a = a ^ 11'($urandom_range(1, 2047));
               if ($urandom_range(0, 49) == 0) d = d ^ 16'($urandom_range(1, 65535));
               cyc(1'b0, $urandom_range(0, 19) == 0, v, a, d);
            end
         end
         idle_n(2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_readback_checker.md
SRAM_READBACK_CHECKER -- requirements
Module: sram_readback_checker

Interface
REQ-001 Parameter NUM_WORDS, default 128, number of read beats per check run (1..2048).
REQ-002 Parameter SEED, default 127, expected data word at index 0.
REQ-003 Parameter TIMEOUT, default 1023, maximum idle cycles between beats before abort (1..65535).
REQ-004 Port clock  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port start  input  1  single-cycle request to begin a check run.
REQ-007 Port rd_valid  input  1  qualifies rd_addr/rd_data as one read-back beat from the SRAM datapath.
REQ-008 Port rd_addr  input  11  address of the current beat.
REQ-009 Port rd_data  input  16  data word read from SRAM at rd_addr.
REQ-010 Port busy  output  1  high while in CHECK.
REQ-011 Port done  output  1  high while in DONE.
REQ-012 Port pass  output  1  high in DONE when err_count is 0.
REQ-013 Port timeout  output  1  high while in TOUT.
REQ-014 Port err_count  output  8  number of mismatching beats in the current run, saturating.
REQ-015 Port first_err_addr  output  11  rd_addr of the first mismatching beat.
REQ-016 Port first_err_data  output  16  rd_data of the first mismatching beat.

Function
REQ-017 The checker SHALL implement four states: IDLE, CHECK, DONE, TOUT; all outputs SHALL be registered.
REQ-018 IDLE -> CHECK on start; idx, err_count, first_err_*, and idle counter SHALL clear on that edge.
REQ-019 In CHECK, each cycle with rd_valid SHALL be one beat: expected address = idx, expected data = (SEED - idx) mod 2^16, idx then increments by 1.
REQ-020 A beat SHALL count as an error when rd_addr != idx[10:0] or rd_data != expected data.
REQ-021 err_count SHALL increment by 1 per error beat and hold at 255 once reached.
REQ-022 first_err_addr/first_err_data SHALL capture only on the first error beat of a run and hold thereafter.
REQ-023 CHECK -> DONE on the edge sampling beat index NUM_WORDS-1; done/pass SHALL be visible the following cycle, reflecting that final beat's comparison.
REQ-024 In CHECK, the idle counter SHALL increment each cycle without rd_valid and clear on every beat; when it reaches TIMEOUT the FSM SHALL go to TOUT.
REQ-025 A beat and idle-counter expiry SHALL never coincide; rd_valid in that cycle SHALL be processed as a beat and the counter cleared.
REQ-026 start while in CHECK SHALL be ignored; start in DONE or TOUT SHALL begin a new run exactly as from IDLE.
REQ-027 rd_valid outside CHECK SHALL be ignored and SHALL NOT modify any counter or output.
REQ-028 err_count and first_err_* SHALL remain stable in DONE and TOUT until the next start or rst.
REQ-029 pass SHALL be 0 in every state except DONE.

Reset
REQ-030 rst SHALL override all other inputs, including start, on the same edge.
REQ-031 After rst: state IDLE, busy=0, done=0, pass=0, timeout=0, err_count=0, first_err_addr=0, first_err_data=0, idx=0, idle counter=0.
REQ-032 rst asserted mid-run SHALL abort the run with no residual error information.

Verification
REQ-033 Clean run: start, 128 back-to-back beats addr 0..127 data 127..0 -> done=1, pass=1, err_count=0 one cycle after beat 127.
REQ-034 Corrupt data: same run with beat 5 data 0x0000 -> done=1, pass=0, err_count=1, first_err_addr=5, first_err_data=0x0000.
REQ-035 Gapped + saturation: beats with 3-cycle gaps, all data 0xFFFF (NUM_WORDS=300) -> no timeout, err_count=255, first_err_addr=0.
REQ-036 Timeout: start, 10 good beats, then rd_valid low for TIMEOUT cycles -> timeout=1, busy=0, err_count=0; a subsequent start clears timeout and sets busy=1.
REQ-037 Address skip: beat addr sequence 0,1,3 with correct data for idx -> err_count=1, first_err_addr=3.
REQ-038 Reset mid-run: rst at beat 60 after an error at beat 10 -> next cycle all outputs 0, state IDLE; start in the same cycle as rst is ignored.
